// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM subsystem. Each frame is a 2-bit command
// followed by a DATA_W-bit payload. Read-data frames return tx_data on MISO, MSB first.
module spi_slave_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              frame_err,
  output logic [1:0]        err_cause
);

  localparam int unsigned FrameW = DATA_W + 2;
  localparam int unsigned CntW   = $clog2(DATA_W + 3);
  localparam int unsigned WaitW  = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StChkCmd, StRecv, StWaitTx, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic                miso_q, miso_d;
  logic [FrameW-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic [1:0]          err_cause_q, err_cause_d;
  logic                rd_addr_seen_q, rd_addr_seen_d;

  logic [FrameW-1:0]   frame_shift;
  logic [1:0]          cmd;
  logic                abort;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wait_d         = wait_q;
    frame_d        = frame_q;
    tx_sh_d        = tx_sh_q;
    miso_d         = miso_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    err_cause_d    = err_cause_q;
    rd_addr_seen_d = rd_addr_seen_q;
    frame_shift    = {frame_q[FrameW-2:0], MOSI};
    cmd            = frame_shift[FrameW-1:FrameW-2];
    abort          = SS_n && (state_q inside {StChkCmd, StRecv, StWaitTx, StSend});

    // Deselect mid-transfer outranks frame completion and tx_valid.
    if (abort) begin
      state_d     = StIdle;
      miso_d      = 1'b0;
      frame_err_d = 1'b1;
      err_cause_d = 2'b01;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!SS_n) begin
            state_d = StChkCmd;
            cnt_d   = '0;
          end
        end
        StChkCmd: begin
          frame_d = frame_shift;
          cnt_d   = CntW'(1);
          state_d = StRecv;
        end
        StRecv: begin
          frame_d = frame_shift;
          if (cnt_q == CntW'(FrameW - 1)) begin
            cnt_d      = CntW'(FrameW);
            rx_data_d  = frame_shift;
            rx_valid_d = 1'b1;
            if (cmd == 2'b10) rd_addr_seen_d = 1'b1;
            if (cmd == 2'b11) begin
              rd_addr_seen_d = 1'b0;
              if (!rd_addr_seen_q) begin
                frame_err_d = 1'b1;
                err_cause_d = 2'b11;
              end
              wait_d  = '0;
              state_d = StWaitTx;
            end else begin
              state_d = StDone;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWaitTx: begin
          if (tx_valid) begin
            tx_sh_d = tx_data << 1;
            miso_d  = tx_data[DATA_W-1];
            cnt_d   = '0;
            state_d = StSend;
          end else if (wait_q == WaitW'(TX_TIMEOUT - 1)) begin
            wait_d      = WaitW'(TX_TIMEOUT);
            frame_err_d = 1'b1;
            err_cause_d = 2'b10;
            state_d     = StDone;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StSend: begin
          // cnt counts bits already presented on MISO since the capture edge.
          if (cnt_q == CntW'(DATA_W - 1)) begin
            miso_d  = 1'b0;
            state_d = StDone;
          end else begin
            miso_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = tx_sh_q << 1;
            cnt_d   = cnt_q + CntW'(1);
          end
        end
        StDone: begin
          miso_d = 1'b0;
          if (SS_n) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      wait_q         <= '0;
      frame_q        <= '0;
      tx_sh_q        <= '0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      err_cause_q    <= 2'b00;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wait_q         <= wait_d;
      frame_q        <= frame_d;
      tx_sh_q        <= tx_sh_d;
      miso_q         <= miso_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
      err_cause_q    <= err_cause_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign err_cause = err_cause_q;
  assign tx_ready  = (state_q == StWaitTx);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised bench for spi_slave_param: a frame-level model predicts rx/error events and
// per-cycle MISO/tx_ready; a monitor checks them against the DUT.
module tb_spi_slave_param;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy, frame_err;
  logic [1:0] err_cause;

  spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_err(frame_err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  typedef struct {logic [9:0] val; int cyc;} ev_t;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  ev_t  rx_q[$];
  ev_t  err_q[$];
  bit   exp_miso[int];
  bit   exp_ready[int];
  bit   seen = 1'b0;
  logic [9:0] last_rx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    ev_t ev;
    #1;
    while (rx_q.size() > 0 && rx_q[0].cyc < cyc) begin
      ev = rx_q.pop_front();
      check("rx_valid_missing", 32'(0), 32'(1));
    end
    while (err_q.size() > 0 && err_q[0].cyc < cyc) begin
      ev = err_q.pop_front();
      check("frame_err_missing", 32'(0), 32'(1));
    end
    if (rx_valid) begin
      if (rx_q.size() == 0) check("rx_valid_unexpected", 32'(1), 32'(0));
      else begin
        ev = rx_q.pop_front();
        check("rx_cycle", 32'(cyc), 32'(ev.cyc));
        check("rx_data", 32'(rx_data), 32'(ev.val));
      end
    end
    if (frame_err) begin
      if (err_q.size() == 0) check("frame_err_unexpected", 32'(1), 32'(0));
      else begin
        ev = err_q.pop_front();
        check("err_cycle", 32'(cyc), 32'(ev.cyc));
        check("err_cause", 32'(err_cause), 32'(ev.val));
      end
    end
    check("miso", 32'(MISO), 32'(exp_miso.exists(cyc) ? exp_miso[cyc] : 1'b0));
    check("tx_ready", 32'(tx_ready), 32'(exp_ready.exists(cyc) ? exp_ready[cyc] : 1'b0));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // abort_bits: frame bits sent before SS_n rises (-1: none). txd: tx_valid delay in WAIT_TX
  // cycles (0: never). rst_k: SEND cycle at which rst_n pulses (-1: none).
  task automatic run_frame(input logic [1:0] cmd, input logic [7:0] pay, input int abort_bits,
                           input int txd, input logic [7:0] rdata, input int rst_k);
    logic [9:0] fr;
    int comp, end_cyc, cap;
    fr = {cmd, pay};
    tick();
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == abort_bits) begin
        SS_n = 1'b1;
        err_q.push_back('{val: 10'd1, cyc: cyc + 1});
        tick();
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_rx_data", 32'(rx_data), 32'(last_rx));
        return;
      end
      MOSI = fr[9-i];
    end
    comp = cyc + 1;
    end_cyc = comp;
    rx_q.push_back('{val: fr, cyc: comp});
    last_rx = fr;
    if (cmd == 2'b10) seen = 1'b1;
    if (cmd == 2'b11) begin
      if (!seen) err_q.push_back('{val: 10'd3, cyc: comp});
      seen = 1'b0;
      if (txd == 0) begin
        for (int c = 0; c < 16; c++) exp_ready[comp + c] = 1'b1;
        err_q.push_back('{val: 10'd2, cyc: comp + 16});
        end_cyc = comp + 16;
      end else begin
        cap = comp + txd;
        for (int c = comp; c < cap; c++) exp_ready[c] = 1'b1;
        for (int k = 0; k < 8; k++)
          if (rst_k < 0 || k <= rst_k) exp_miso[cap + k] = rdata[7-k];
        tick();
        while (cyc < cap - 1) begin
          MOSI = 1'($urandom);
          tx_data = 8'($urandom);
          tick();
        end
        tx_valid = 1'b1;
        tx_data = rdata;
        tick();
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        if (rst_k >= 0) begin
          while (cyc < cap + rst_k) tick();
          rst_n = 1'b0;
          SS_n = 1'b1;
          tick();
          rst_n = 1'b1;
          check("rst_miso", 32'(MISO), 32'(0));
          check("rst_busy", 32'(busy), 32'(0));
          check("rst_rx_data", 32'(rx_data), 32'(0));
          seen = 1'b0;
          last_rx = '0;
          return;
        end
        end_cyc = cap + 8;
      end
    end
    // Linger in DONE with junk MOSI before deselecting.
    repeat ($urandom_range(0, 3)) begin
      tick();
      MOSI = 1'($urandom);
    end
    while (cyc < end_cyc) begin
      tick();
      MOSI = 1'($urandom);
    end
    SS_n = 1'b1;
    tick();
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick(); tick();
    check("reset_miso", 32'(MISO), 32'(0));
    check("reset_rx_valid", 32'(rx_valid), 32'(0));
    check("reset_frame_err", 32'(frame_err), 32'(0));
    check("reset_rx_data", 32'(rx_data), 32'(0));
    check("reset_err_cause", 32'(err_cause), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    tick();

    run_frame(2'b00, 8'hA5, -1, 0, 8'h00, -1);
    run_frame(2'b10, 8'h30, -1, 0, 8'h00, -1);
    run_frame(2'b11, 8'h5A, -1, 3, 8'h3C, -1);
    run_frame(2'b11, 8'h11, -1, 5, 8'hC3, -1);
    run_frame(2'b01, 8'hFF, 7, 0, 8'h00, -1);
    run_frame(2'b10, 8'h44, -1, 0, 8'h00, -1);
    run_frame(2'b11, 8'h44, -1, 0, 8'h00, -1);
    run_frame(2'b10, 8'h77, -1, 0, 8'h00, -1);
    run_frame(2'b11, 8'h77, -1, 2, 8'hB6, 3);
    run_frame(2'b00, 8'h12, -1, 0, 8'h00, -1);

    for (int n = 0; n < 40; n++) begin
      run_frame(2'($urandom), 8'($urandom),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1,
                int'($urandom_range(0, 16)), 8'($urandom), -1);
    end

    repeat (4) tick();
    check("rx_queue_drained", 32'(rx_q.size()), 32'(0));
    check("err_queue_drained", 32'(err_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
